fetch_unit: RTL and testbench

Instruction-fetch stage of the 16-bit CPU, directly upstream of the PC-control logic. It owns the architectural PC register, drives the instruction-memory request handshake, presents the current PC to the next-PC logic, and registers the fetched instruction into the IF/ID pipeline register. It also handles stall, flush-redirect and halt.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/sat_counter16.sv | 20 ++
 rtl/fetch_unit.sv | 170 +++++++++++++++++
 tb/tb_fetch_unit.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        HOLD,
        DRAIN,
        HALTED
    } fetch_state_t;

    localparam logic [15:0] INSTR_NOP        = 16'h0000;
    localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

    // Instructions are 2 bytes; the sum wraps silently at 16 bits.
    function automatic logic [15:0] pc_plus2(input logic [15:0] pc);
        return pc + 16'd2;
    endfunction

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    output logic [15:0] o_count
);

    logic [15:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_count <= '0;
        else if (i_en && (r_count != 16'hFFFF))
            r_count <= r_count + 16'd1;
    end

    assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, imem handshake, IF/ID register, stall/flush/halt.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] pc_cur,
    input  logic [15:0] pc_next,
    input  logic        halt,
    input  logic        stall,
    input  logic        flush,
    input  logic [15:0] flush_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic        ifid_valid,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc2,
    output logic        halted,
    output logic [15:0] perf_fetches,
    output logic [15:0] perf_stalls
);

    fetch_state_t r_state, w_state_nxt;
    logic [15:0]  r_pc, w_pc_nxt;
    logic [15:0]  r_req_addr, w_ra_nxt;
    logic [15:0]  r_hold, w_hold_nxt;
    logic         r_ifid_valid, w_ifid_valid_nxt;
    logic [15:0]  r_ifid_instr, w_ifid_instr_nxt;
    logic [15:0]  r_ifid_pc2, w_ifid_pc2_nxt;
    logic         w_accept;
    logic [15:0]  w_word;
    logic         w_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_pc         <= RESET_PC;
            r_req_addr   <= RESET_PC;
            r_hold       <= INSTR_NOP;
            r_ifid_valid <= 1'b0;
            r_ifid_instr <= INSTR_NOP;
            r_ifid_pc2   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_req_addr   <= w_ra_nxt;
            r_hold       <= w_hold_nxt;
            r_ifid_valid <= w_ifid_valid_nxt;
            r_ifid_instr <= w_ifid_instr_nxt;
            r_ifid_pc2   <= w_ifid_pc2_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ra_nxt    = r_req_addr;
        w_hold_nxt  = r_hold;
        w_accept    = 1'b0;
        w_word      = imem_rdata;
        w_req       = 1'b0;

        case (r_state)
            IDLE: begin
                w_state_nxt = FETCH;
                w_pc_nxt    = flush ? flush_pc : r_pc;
                w_ra_nxt    = flush ? flush_pc : r_pc;
            end
            FETCH: begin
                w_req = 1'b1;
                if (imem_ack && flush) begin
                    w_pc_nxt = flush_pc;
                    w_ra_nxt = flush_pc;
                end else if (imem_ack && stall) begin
                    w_hold_nxt  = imem_rdata;
                    w_state_nxt = HOLD;
                end else if (imem_ack) begin
                    w_accept = 1'b1;
                end else if (flush) begin
                    // The old request stays on the bus until memory answers it.
                    w_pc_nxt    = flush_pc;
                    w_state_nxt = DRAIN;
                end
            end
            HOLD: begin
                if (flush) begin
                    w_pc_nxt    = flush_pc;
                    w_ra_nxt    = flush_pc;
                    w_state_nxt = FETCH;
                end else if (!stall) begin
                    w_accept = 1'b1;
                    w_word   = r_hold;
                end
            end
            DRAIN: begin
                w_req = 1'b1;
                if (flush)
                    w_pc_nxt = flush_pc;
                if (imem_ack) begin
                    w_state_nxt = FETCH;
                    w_ra_nxt    = flush ? flush_pc : r_pc;
                end
            end
            HALTED: ;
            default: w_state_nxt = IDLE;
        endcase

        if (w_accept) begin
            if (halt) begin
                w_state_nxt = HALTED;
            end else begin
                w_pc_nxt    = pc_next;
                w_ra_nxt    = pc_next;
                w_state_nxt = FETCH;
            end
        end

        w_ifid_valid_nxt = r_ifid_valid;
        w_ifid_instr_nxt = r_ifid_instr;
        w_ifid_pc2_nxt   = r_ifid_pc2;
        if (r_state != HALTED) begin
            if (w_accept) begin
                w_ifid_valid_nxt = 1'b1;
                w_ifid_instr_nxt = w_word;
                w_ifid_pc2_nxt   = pc_plus2(r_pc);
            end else if (flush) begin
                w_ifid_valid_nxt = 1'b0;
                w_ifid_instr_nxt = INSTR_NOP;
            end else if (!stall) begin
                w_ifid_valid_nxt = 1'b0;
            end
        end
    end

    assign pc_cur     = r_pc;
    assign imem_req   = w_req;
    assign imem_addr  = r_req_addr;
    assign ifid_valid = r_ifid_valid;
    assign ifid_instr = r_ifid_instr;
    assign ifid_pc2   = r_ifid_pc2;
    assign halted     = (r_state == HALTED);

`ifdef FETCH_PERF_EN
    logic w_stall_cnt_en;
    assign w_stall_cnt_en = stall && (r_state != HALTED);

    sat_counter16 u_cnt_fetch (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_accept),
        .o_count (perf_fetches)
    );

    sat_counter16 u_cnt_stall (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_stall_cnt_en),
        .o_count (perf_stalls)
    );
`else
    assign perf_fetches = '0;
    assign perf_stalls  = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: transaction-level model of the fetch path, scoreboard on IF/ID.
module tb_fetch_unit;
    import fetch_pkg::*;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc2;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc_cur, pc_next, flush_pc, imem_addr, imem_rdata;
    logic [15:0] ifid_instr, ifid_pc2, perf_fetches, perf_stalls;
    logic        halt, stall, flush, imem_req, imem_ack, ifid_valid, halted;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst), .pc_cur(pc_cur), .pc_next(pc_next), .halt(halt),
        .stall(stall), .flush(flush), .flush_pc(flush_pc), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc2(ifid_pc2),
        .halted(halted), .perf_fetches(perf_fetches), .perf_stalls(perf_stalls)
    );

    // Stand-in PC control: sequential flow with a jump out of every 64-byte block end.
    function automatic logic [15:0] next_pc(input logic [15:0] a);
        return (a[5:0] == 6'h3E) ? a + 16'h0102 : a + 16'h0002;
    endfunction
    assign pc_next = next_pc(pc_cur);

    logic        fixed_en;
    logic [15:0] fixed_val;
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return fixed_en ? fixed_val : ({a[7:0], a[15:8]} ^ 16'h3C5A);
    endfunction

    int   n_tests = 0, n_fail = 0;
    exp_t exp_q[$];

    // Reference model state: where the next useful fetch must go.
    logic [15:0] exp_addr, dead_addr, held_a, held_w;
    logic        dead, held, m_halted, busy;
    int          lat, force_lat;
    int          n_acc, n_stall;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_fetches();
`ifdef FETCH_PERF_EN
        return 16'(n_acc);
`else
        return 16'h0000;
`endif
    endfunction

    function automatic logic [15:0] exp_stalls();
`ifdef FETCH_PERF_EN
        return 16'(n_stall);
`else
        return 16'h0000;
`endif
    endfunction

    task automatic accept(input logic [15:0] a, input logic [15:0] w, input logic h);
        exp_q.push_back('{instr: w, pc2: a + 16'd2});
        n_acc++;
        if (h) m_halted = 1'b1;
        else   exp_addr = next_pc(a);
    endtask

    // One clock of stimulus: memory response plus model update for the coming edge.
    task automatic step(input logic f, input logic [15:0] fpc, input logic s, input logic h);
        logic k;
        @(negedge clk);
        chk("pc_cur", pc_cur, exp_addr);
        chk("perf_fetches", perf_fetches, exp_fetches());
        chk("perf_stalls", perf_stalls, exp_stalls());
        flush = f; flush_pc = fpc; stall = s; halt = h;
        k = 1'b0;
        if (imem_req) begin
            if (!busy) begin
                busy = 1'b1;
                lat  = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
            end
            if (lat == 0) begin k = 1'b1; busy = 1'b0; end
            else lat--;
        end
        imem_ack   = k;
        imem_rdata = k ? mem_word(imem_addr) : 16'hDEAD;
        if (s && !m_halted) n_stall++;

        if (k) begin
            chk("ack_addr", imem_addr, dead ? dead_addr : exp_addr);
            if (dead) begin
                dead = 1'b0;
                if (f) exp_addr = fpc;
            end else if (f) begin
                exp_addr = fpc;
            end else if (s) begin
                held = 1'b1; held_a = exp_addr; held_w = mem_word(exp_addr);
            end else begin
                accept(exp_addr, mem_word(exp_addr), h);
            end
        end else if (imem_req) begin
            if (f) begin
                if (!dead) begin dead = 1'b1; dead_addr = exp_addr; end
                exp_addr = fpc;
            end
        end else if (held) begin
            if (f) begin held = 1'b0; exp_addr = fpc; end
            else if (!s) begin held = 1'b0; accept(held_a, held_w, h); end
        end else if (f && !m_halted) begin
            exp_addr = fpc;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; flush = 1'b0; stall = 1'b0; halt = 1'b0; imem_ack = 1'b0;
        flush_pc = 16'h0000; imem_rdata = 16'hDEAD;
        busy = 1'b0; dead = 1'b0; held = 1'b0; m_halted = 1'b0;
        exp_addr = 16'h0000; n_acc = 0; n_stall = 0;
        #1;
        chk("rst_pc", pc_cur, 16'h0000);
        chk("rst_req", 16'(imem_req), 16'h0);
        chk("rst_addr", imem_addr, 16'h0000);
        chk("rst_valid", 16'(ifid_valid), 16'h0);
        chk("rst_instr", ifid_instr, INSTR_NOP);
        chk("rst_pc2", ifid_pc2, 16'h0000);
        chk("rst_halted", 16'(halted), 16'h0);
        chk("rst_perf_f", perf_fetches, 16'h0000);
        chk("rst_perf_s", perf_stalls, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("idle_req", 16'(imem_req), 16'h0);
    endtask

    // Monitor: every edge, a freshly accepted instruction must match the scoreboard head.
    logic mon_frozen = 1'b0;
    exp_t e;
    initial forever begin
        @(posedge clk);
        #1;
        if (!rst && !mon_frozen) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ifid_valid", 16'(ifid_valid), 16'h1);
                chk("ifid_instr", ifid_instr, e.instr);
                chk("ifid_pc2", ifid_pc2, e.pc2);
            end else if (ifid_valid && !stall) begin
                chk("spurious_ifid", 16'(ifid_valid), 16'h0);
            end
            if (flush) begin
                chk("flush_valid", 16'(ifid_valid), 16'h0);
                chk("flush_nop", ifid_instr, INSTR_NOP);
            end
        end
        mon_frozen = m_halted && !rst;
    end

    initial begin
        rst = 1'b1; flush = 1'b0; stall = 1'b0; halt = 1'b0; imem_ack = 1'b0;
        flush_pc = '0; imem_rdata = '0; fixed_en = 1'b0; fixed_val = '0;
        busy = 1'b0; dead = 1'b0; held = 1'b0; m_halted = 1'b0; lat = 0;
        exp_addr = '0; dead_addr = '0; held_a = '0; held_w = '0;
        force_lat = 0; n_acc = 0; n_stall = 0;

        // Zero-wait streaming of a constant word.
        do_reset();
        fixed_en = 1'b1; fixed_val = 16'hA001;
        repeat (4) step(1'b0, 16'h0, 1'b0, 1'b0);

        // Wait states at 0x0010.
        fixed_en = 1'b0;
        step(1'b1, 16'h0010, 1'b0, 1'b0);
        force_lat = 3;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 16'h0, 1'b0, 1'b0);
            chk("wait_req", 16'(imem_req), 16'h1);
            chk("wait_addr", imem_addr, 16'h0010);
        end
        repeat (2) step(1'b0, 16'h0, 1'b0, 1'b0);

        // Stall coinciding with the ack of 0x1234.
        do_reset();
        force_lat = 0; fixed_en = 1'b1; fixed_val = 16'h1234;
        step(1'b0, 16'h0, 1'b1, 1'b0);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        chk("hold_req", 16'(imem_req), 16'h0);
        fixed_en = 1'b0;
        repeat (2) step(1'b0, 16'h0, 1'b0, 1'b0);

        // Redirect while a request is outstanding.
        force_lat = 3;
        step(1'b0, 16'h0, 1'b0, 1'b0);
        step(1'b1, 16'h0100, 1'b0, 1'b0);
        repeat (8) step(1'b0, 16'h0, 1'b0, 1'b0);

        // Halt at 0x0020, then reset out of it.
        do_reset();
        force_lat = 0;
        step(1'b1, 16'h0020, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 16'h0, 1'b0, 1'b0);
            chk("halted", 16'(halted), 16'h1);
            chk("halt_req", 16'(imem_req), 16'h0);
            chk("halt_pc", pc_cur, 16'h0020);
        end
        do_reset();

        // PC+2 wraps at the top of the address space.
        force_lat = 0;
        step(1'b1, 16'hFFFE, 1'b0, 1'b0);
        repeat (2) step(1'b0, 16'h0, 1'b0, 1'b0);

        // Randomised latency, stalls and redirects.
        force_lat = -1;
        for (int i = 0; i < 2000; i++)
            step(($urandom_range(0, 15) == 0), 16'($urandom) & 16'hFFFE,
                 ($urandom_range(0, 4) == 0), 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0);

        @(negedge clk);
        chk("queue_empty", 16'(exp_q.size()), 16'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
